// File: rtl/icache_fill_server.sv
// ---------------------------------------------------------------------------
// icache_fill_server
//
// Memory-side responder for the instruction-cache line-fill protocol. A line
// request is split into word reads to the SDRAM controller. At most
// MAX_OUTSTANDING reads are in flight at once. The returned words are
// buffered, and the whole line is then streamed back to the cache as one
// gap-free burst of sdram_ack cycles.
//
// Optional feature macro: ICACHE_FILL_LINEBUF_EN
//   defined   : the buffer keeps the last completed line and its base. A
//               matching request streams straight from the buffer without
//               issuing any reads. line_inval drops the held line.
//   undefined : every request is fetched, and line_inval is ignored.
//
// Ports
//   sdram_clk    sole clock
//   reset        asynchronous active-high reset
//   icache_ren   line-fill request (level), sampled only in IDLE
//   icache_addr  word address of the line; bits [ADDR_W-1:0] are used
//   sdram_in     line word to the cache; holds the last word after a burst
//   sdram_ack    high for exactly LINE_WORDS consecutive cycles per fill
//   mem_req      word read request to the SDRAM controller
//   mem_addr     word address of mem_req
//   mem_ready    controller accepts mem_req this cycle
//   mem_rdata    read data
//   mem_rvalid   read data valid; responses return in request order
//   line_inval   invalidates the held line (feature build only)
//   busy         high in any state other than IDLE
// ---------------------------------------------------------------------------
module icache_fill_server #(
  parameter int LINE_WORDS      = 16,
  parameter int ADDR_W          = 21,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              sdram_clk,
  input  logic              reset,
  input  logic              icache_ren,
  input  logic [31:0]       icache_addr,
  output logic [31:0]       sdram_in,
  output logic              sdram_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic              line_inval,
  output logic              busy
);

  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     recv_cnt_q, recv_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              sdram_ack_q, sdram_ack_d;
  logic              busy_q, busy_d;
  logic [31:0]       sdram_in_q, sdram_in_d;

  logic [31:0]       line_buf [LINE_WORDS];
  logic [ADDR_W-1:0] req_base;
  logic              accept;
  logic              capture;
  logic              hit;
  logic [31:0]       first_word;
  logic              unused_bits;

  assign req_base = icache_addr[ADDR_W-1:0] & ~ADDR_W'(LINE_WORDS - 1);

  // mem_req is only ever high in FETCH. A response counts only while a
  // read is actually outstanding, so stray data is dropped.
  assign accept  = mem_req_q & mem_ready;
  assign capture = (state_q == FETCH) && mem_rvalid && (issue_cnt_q != recv_cnt_q);

`ifdef ICACHE_FILL_LINEBUF_EN
  logic valid_q, valid_d;
  assign hit         = valid_q && (base_q == req_base);
  assign unused_bits = ^icache_addr[31:ADDR_W];
`else
  assign hit         = 1'b0;
  assign unused_bits = ^{icache_addr[31:ADDR_W], line_inval};
`endif

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    out_cnt_d   = out_cnt_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = 1'b0;
    sdram_ack_d = 1'b0;
    sdram_in_d  = sdram_in_q;
`ifdef ICACHE_FILL_LINEBUF_EN
    valid_d     = valid_q;
`endif
    // Word 0 bypasses the buffer when it is being written on this same edge.
    // This only happens for single-word lines.
    first_word  = (capture && recv_cnt_q[IW-1:0] == '0) ? mem_rdata : line_buf[0];

    case (state_q)
      IDLE: begin
        if (icache_ren) begin
          base_d = req_base;
          if (hit) begin
            state_d     = STREAM;
            sdram_ack_d = 1'b1;
            sdram_in_d  = line_buf[0];
            out_cnt_d   = CW'(1);
          end else begin
            state_d     = FETCH;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            mem_req_d   = 1'b1;
            mem_addr_d  = req_base;
`ifdef ICACHE_FILL_LINEBUF_EN
            valid_d     = 1'b0;  // the buffer is about to be overwritten
`endif
          end
        end
      end

      FETCH: begin
        issue_cnt_d = issue_cnt_q + CW'(accept);
        recv_cnt_d  = recv_cnt_q + CW'(capture);
        if (recv_cnt_d == CW'(LINE_WORDS)) begin
          // Start the burst on the same edge that captures the last word.
          state_d     = STREAM;
          sdram_ack_d = 1'b1;
          sdram_in_d  = first_word;
          out_cnt_d   = CW'(1);
`ifdef ICACHE_FILL_LINEBUF_EN
          valid_d     = 1'b1;
`endif
        end else begin
          // The next-cycle request is computed from the post-edge counts.
          // This lets accepted requests run back to back without a bubble.
          mem_req_d = (issue_cnt_d < CW'(LINE_WORDS)) &&
                      ((issue_cnt_d - recv_cnt_d) < CW'(MAX_OUTSTANDING));
          if (mem_req_d) begin
            mem_addr_d = base_q + ADDR_W'(issue_cnt_d);
          end
        end
      end

      STREAM: begin
        if (out_cnt_q == CW'(LINE_WORDS)) begin
          state_d = GAP;  // sdram_in keeps the last word
        end else begin
          sdram_ack_d = 1'b1;
          sdram_in_d  = line_buf[out_cnt_q[IW-1:0]];
          out_cnt_d   = out_cnt_q + CW'(1);
        end
      end

      GAP: begin
        if (!icache_ren) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef ICACHE_FILL_LINEBUF_EN
    if (line_inval) begin
      valid_d = 1'b0;  // wins over a fill completing on the same edge
    end
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      out_cnt_q   <= '0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      sdram_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      sdram_in_q  <= '0;
`ifdef ICACHE_FILL_LINEBUF_EN
      valid_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      out_cnt_q   <= out_cnt_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      sdram_ack_q <= sdram_ack_d;
      busy_q      <= busy_d;
      sdram_in_q  <= sdram_in_d;
`ifdef ICACHE_FILL_LINEBUF_EN
      valid_q     <= valid_d;
`endif
    end
  end

  // Line storage has no reset. Its contents only matter once a fill has
  // written them.
  always_ff @(posedge sdram_clk) begin
    if (capture) begin
      line_buf[recv_cnt_q[IW-1:0]] <= mem_rdata;
    end
  end

  assign sdram_in  = sdram_in_q;
  assign sdram_ack = sdram_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_icache_fill_server.sv
// ---------------------------------------------------------------------------
// tb_icache_fill_server
//
// Bench for icache_fill_server. A behavioural SDRAM port returns a unique,
// address-derived word for each accepted read. Its response rate is
// adjustable. Each fill checks the following:
//   - the request/ack timing;
//   - every burst word, in order;
//   - the low cycle after the burst, with the last word still held;
//   - the issued address sequence;
//   - the peak number of outstanding reads.
// Build with ICACHE_FILL_LINEBUF_EN to exercise the line-buffer hit path.
// ---------------------------------------------------------------------------
module tb_icache_fill_server;
  localparam int LW = 16;
  localparam int AW = 21;
  localparam int MO = 4;
`ifdef ICACHE_FILL_LINEBUF_EN
  localparam bit HIT_FETCH = 1'b0;
`else
  localparam bit HIT_FETCH = 1'b1;
`endif

  logic          sdram_clk = 1'b0;
  logic          reset = 1'b1;
  logic          icache_ren = 1'b0;
  logic [31:0]   icache_addr = '0;
  logic [31:0]   sdram_in;
  logic          sdram_ack;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid;
  logic          line_inval = 1'b0;
  logic          busy;

  icache_fill_server #(.LINE_WORDS(LW), .ADDR_W(AW), .MAX_OUTSTANDING(MO)) dut (
    .sdram_clk  (sdram_clk),
    .reset      (reset),
    .icache_ren (icache_ren),
    .icache_addr(icache_addr),
    .sdram_in   (sdram_in),
    .sdram_ack  (sdram_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .line_inval (line_inval),
    .busy       (busy)
  );

  always #5 sdram_clk = ~sdram_clk;

  int n_checks = 0;
  int n_err = 0;

  // Memory model state
  int            ready_pct = 100;
  int            rvalid_pct = 100;
  bit            mem_en = 1'b1;
  int            stray_n = 0;
  int            cyc = 0;
  int            issued_n = 0;
  int            rx_n = 0;
  int            max_out = 0;
  bit            last_acc = 1'b0;
  bit            last_rv = 1'b0;
  logic [AW-1:0] pend_a[$];
  int            pend_c[$];
  logic [AW-1:0] addr_log[$];

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return {11'h52D, a} ^ 32'h0013_5700;
  endfunction

  // Drives decisions at the negedge, which the DUT consumes at the next
  // posedge. Reads are answered no earlier than 2 cycles after acceptance.
  initial begin : mem_model
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge sdram_clk);
      cyc++;
      if (last_acc) issued_n++;
      if (last_rv) rx_n++;
      if (issued_n - rx_n > max_out) max_out = issued_n - rx_n;
      if (mem_en) begin
        mem_ready = ($urandom_range(99) < ready_pct);
        last_acc  = mem_req && mem_ready;
        if (last_acc) begin
          pend_a.push_back(mem_addr);
          pend_c.push_back(cyc);
          addr_log.push_back(mem_addr);
        end
        if (pend_a.size() > 0 && pend_c[0] + 2 <= cyc && $urandom_range(99) < rvalid_pct) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mdata(pend_a.pop_front());
          void'(pend_c.pop_front());
          last_rv = 1'b1;
        end else begin
          mem_rvalid = 1'b0;
          last_rv = 1'b0;
        end
      end else begin
        mem_ready = 1'b0;
        last_acc  = 1'b0;
        last_rv   = 1'b0;
        if (stray_n > 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hDEAD_BEEF;
          stray_n--;
        end else begin
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge sdram_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    issued_n = 0;
    rx_n = 0;
    max_out = 0;
    addr_log.delete();
    pend_a.delete();
    pend_c.delete();
  endtask

  task automatic run_fill(input logic [31:0] addr, input logic [AW-1:0] base,
                          input int rdy, input int rv, input bit hold, input bit exp_fetch);
    int waits;
    int bad;
    ready_pct  = rdy;
    rvalid_pct = rv;
    clear_model();
    icache_addr = addr;
    icache_ren  = 1'b1;
    tick();
    if (!hold) icache_ren = 1'b0;
    if (exp_fetch) begin
      chk("req_start", 32'(mem_req), 32'd1);
      chk("first_addr", 32'(mem_addr), 32'(base));
    end
    waits = 1;
    while (!sdram_ack && waits < 3000) begin
      tick();
      waits++;
    end
    if (!sdram_ack) begin
      chk("ack_timeout", 32'(sdram_ack), 32'd1);
      icache_ren = 1'b0;
      return;
    end
    if (!exp_fetch) chk("hit_latency", 32'(waits), 32'd1);
    for (int k = 0; k < LW; k++) begin
      chk($sformatf("ack_run%0d", k), 32'(sdram_ack), 32'd1);
      chk($sformatf("word%0d", k), sdram_in, mdata(base + AW'(k)));
      tick();
    end
    chk("ack_low_after", 32'(sdram_ack), 32'd0);
    chk("in_holds_last", sdram_in, mdata(base + AW'(LW - 1)));
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("gap_hold", 32'({busy, mem_req, sdram_ack}), 32'b100);
      end
      icache_ren = 1'b0;
    end
    tick();
    chk("idle_return", 32'(busy), 32'd0);
    chk("addr_count", 32'(addr_log.size()), exp_fetch ? 32'd16 : 32'd0);
    bad = 0;
    for (int k = 0; k < addr_log.size(); k++) begin
      if (addr_log[k] !== base + AW'(k)) bad++;
    end
    chk("addr_seq", 32'(bad), 32'd0);
    chk("max_outstanding_ok", 32'(max_out <= MO), 32'd1);
    $display("fill addr=%h base=%h fetch=%0d max_out=%0d errors=%0d", addr, base, exp_fetch, max_out, n_err);
  endtask

  typedef struct {
    logic [31:0]   addr;
    int            rdy;
    int            rv;
    logic [AW-1:0] exp_base;
  } vec_t;

  vec_t vecs[4];

  initial begin : test
    int waits;
    vecs[0] = '{addr: 32'h0000_0123, rdy: 100, rv: 100, exp_base: 21'h000120};
    vecs[1] = '{addr: 32'h0000_05A7, rdy: 50,  rv: 50,  exp_base: 21'h0005A0};
    vecs[2] = '{addr: 32'h001F_FFF5, rdy: 100, rv: 100, exp_base: 21'h1FFFF0};
    vecs[3] = '{addr: 32'hFFE0_0043, rdy: 50,  rv: 50,  exp_base: 21'h000040};

    // Reset state
    tick();
    tick();
    chk("rst_ctrl", 32'({busy, mem_req, sdram_ack}), 32'd0);
    chk("rst_in", sdram_in, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_after_rst", 32'({busy, mem_req, sdram_ack}), 32'd0);

    // Table-driven misses: ideal memory, random stalls, wrap corner, high bits
    for (int i = 0; i < 4; i++) begin
      run_fill(vecs[i].addr, vecs[i].exp_base, vecs[i].rdy, vecs[i].rv, 1'b0, 1'b1);
    end

    // Repeat request for a held line, then invalidate and request it again
    run_fill(32'h0000_0123, 21'h000120, 100, 100, 1'b0, 1'b1);
    run_fill(32'h0000_012C, 21'h000120, 100, 100, 1'b0, HIT_FETCH);
    line_inval = 1'b1;
    tick();
    line_inval = 1'b0;
    run_fill(32'h0000_0123, 21'h000120, 100, 100, 1'b0, 1'b1);

    // Request held high through the burst and released 3 cycles into GAP
    run_fill(32'h0000_0789, 21'h000780, 60, 60, 1'b1, 1'b1);

    // Reset mid-fill at recv_cnt = 7, stray responses, then a clean fill
    ready_pct = 100;
    rvalid_pct = 100;
    clear_model();
    icache_addr = 32'h0000_0345;
    icache_ren = 1'b1;
    tick();
    icache_ren = 1'b0;
    waits = 0;
    while (rx_n < 7 && waits < 500) begin
      tick();
      waits++;
    end
    chk("reach_recv7", 32'(rx_n), 32'd7);
    reset = 1'b1;
    #1;
    chk("rst_async_ctrl", 32'({busy, mem_req, sdram_ack}), 32'd0);
    chk("rst_async_in", sdram_in, 32'd0);
    chk("rst_async_addr", 32'(mem_addr), 32'd0);
    mem_en = 1'b0;
    pend_a.delete();
    pend_c.delete();
    stray_n = 3;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stray_ignored", 32'({busy, mem_req, sdram_ack}), 32'd0);
    end
    mem_en = 1'b1;
    tick();
    run_fill(32'h0000_0345, 21'h000340, 100, 100, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
